// File: rtl/inertial_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : inertial_filter
// Purpose  : Per-channel clocked inertial / transport delay for CHANNELS
//            single-bit control lines that are already synchronous to clk.
//            Inertial mode rejects pulses shorter than DELAY_CYC cycles.
//            Transport mode delays every pulse by exactly DELAY_CYC cycles.
// Ports    : clk        rising-edge clock
//            rst_n      asynchronous active-low reset
//            en         1 = operate, 0 = freeze all state (glitch_o forced 0)
//            mode       0 = inertial, 1 = transport
//            din        channel inputs [CHANNELS]
//            dout       filtered / delayed outputs (registered) [CHANNELS]
//            glitch_o   one-cycle pulse per rejected inertial pulse [CHANNELS]
//            busy       registered "something is still in flight" flag
//            cnt_clr    (macro build only) synchronous clear of glitch_cnt
//            glitch_cnt (macro build only) saturating 16-bit rejection count
// Options  : `define INERTIAL_FILTER_GLITCH_CNT_EN adds cnt_clr / glitch_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module inertial_filter #(
  parameter int CHANNELS  = 4,
  parameter int DELAY_CYC = 5,
  parameter bit RST_VAL   = 1'b0,
  localparam int CNT_W    = $clog2(DELAY_CYC + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] glitch_o,
  output logic                busy
`ifdef INERTIAL_FILTER_GLITCH_CNT_EN
  ,
  input  logic                cnt_clr,
  output logic [15:0]         glitch_cnt
`endif
);

  // The dout register is the final stage of the transport line, so only
  // DELAY_CYC-1 extra stages are stored. That keeps transport latency equal to
  // the inertial latency: a value sampled on edge 1 reaches dout on edge
  // DELAY_CYC. With DELAY_CYC==1 one dummy stage exists but is never used.
  localparam int c_LINE_LEN = (DELAY_CYC > 1) ? DELAY_CYC - 1 : 1;
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DELAY_CYC - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t                            r_state    [CHANNELS];
  state_t                            w_state_nxt[CHANNELS];
  logic   [CNT_W-1:0]                r_cnt      [CHANNELS];
  logic   [CNT_W-1:0]                w_cnt_nxt  [CHANNELS];
  logic   [c_LINE_LEN-1:0][CHANNELS-1:0] r_line;
  logic   [c_LINE_LEN-1:0][CHANNELS-1:0] w_line_nxt;
  logic   [CHANNELS-1:0]             r_dout;
  logic   [CHANNELS-1:0]             w_dout_nxt;
  logic   [CHANNELS-1:0]             r_glitch;
  logic   [CHANNELS-1:0]             w_glitch_nxt;
  logic                              r_mode_q;
  logic                              w_mode_nxt;
  logic                              r_busy;
  logic                              w_busy_nxt;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout   <= {CHANNELS{RST_VAL}};
      r_line   <= {(c_LINE_LEN * CHANNELS){RST_VAL}};
      r_glitch <= '0;
      r_busy   <= 1'b0;
      r_mode_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_state[c] <= ST_IDLE;
        r_cnt[c]   <= '0;
      end
    end else begin
      r_dout   <= w_dout_nxt;
      r_line   <= w_line_nxt;
      r_glitch <= w_glitch_nxt;
      r_busy   <= w_busy_nxt;
      r_mode_q <= w_mode_nxt;
      for (int c = 0; c < CHANNELS; c++) begin
        r_state[c] <= w_state_nxt[c];
        r_cnt[c]   <= w_cnt_nxt[c];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. With en=0 every next value equals the current one and
  // the glitch register is cleared.
  // --------------------------------------------------------------------------
  always_comb begin
    w_dout_nxt   = r_dout;
    w_line_nxt   = r_line;
    w_glitch_nxt = '0;
    w_mode_nxt   = r_mode_q;
    for (int c = 0; c < CHANNELS; c++) begin
      w_state_nxt[c] = r_state[c];
      w_cnt_nxt[c]   = r_cnt[c];
    end

    if (en) begin
      w_mode_nxt = mode;
      if (mode != r_mode_q) begin
        // Mode switch: dout holds, both storage structures are re-seeded from
        // dout so the new mode starts from a clean, quiet state.
        w_line_nxt = {c_LINE_LEN{r_dout}};
        for (int c = 0; c < CHANNELS; c++) begin
          w_state_nxt[c] = ST_IDLE;
          w_cnt_nxt[c]   = '0;
        end
      end else if (!r_mode_q) begin
        // Inertial: count consecutive edges with din != dout
        for (int c = 0; c < CHANNELS; c++) begin
          case (r_state[c])
            ST_IDLE: begin
              w_cnt_nxt[c] = '0;
              if (din[c] != r_dout[c]) begin
                if (DELAY_CYC == 1) begin
                  w_dout_nxt[c] = din[c];
                end else begin
                  w_state_nxt[c] = ST_PEND;
                  w_cnt_nxt[c]   = c_CNT_ONE;
                end
              end
            end
            ST_PEND: begin
              if (din[c] != r_dout[c]) begin
                if (r_cnt[c] == c_CNT_LAST) begin
                  w_dout_nxt[c]  = din[c];
                  w_cnt_nxt[c]   = '0;
                  w_state_nxt[c] = ST_IDLE;
                end else begin
                  w_cnt_nxt[c] = r_cnt[c] + c_CNT_ONE;
                end
              end else begin
                // Input fell back before the window closed: pulse rejected
                w_cnt_nxt[c]    = '0;
                w_state_nxt[c]  = ST_IDLE;
                w_glitch_nxt[c] = 1'b1;
              end
            end
            default: begin
              w_cnt_nxt[c]   = '0;
              w_state_nxt[c] = ST_IDLE;
            end
          endcase
        end
      end else begin
        // Transport: shift, dout takes the oldest stored stage
        if (DELAY_CYC == 1) begin
          w_dout_nxt = din;
        end else begin
          w_dout_nxt    = r_line[c_LINE_LEN-1];
          w_line_nxt[0] = din;
          for (int k = 1; k < c_LINE_LEN; k++) begin
            w_line_nxt[k] = r_line[k-1];
          end
        end
      end
    end

    // busy is computed from the next state so that the registered flag
    // describes the registers it is sampled alongside.
    w_busy_nxt = 1'b0;
    if (!w_mode_nxt) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_cnt_nxt[c] != '0) w_busy_nxt = 1'b1;
      end
    end else if (DELAY_CYC > 1) begin
      for (int k = 0; k < c_LINE_LEN; k++) begin
        if (w_line_nxt[k] != w_dout_nxt) w_busy_nxt = 1'b1;
      end
    end
  end

  assign dout     = r_dout;
  assign glitch_o = r_glitch & {CHANNELS{en}};
  assign busy     = r_busy;

`ifdef INERTIAL_FILTER_GLITCH_CNT_EN
  // --------------------------------------------------------------------------
  // Saturating rejection counter. glitch_o is already zero while en=0, so the
  // count naturally stops advancing when the filter is frozen.
  // --------------------------------------------------------------------------
  logic [15:0] r_gcnt;
  logic [16:0] w_gsum;

  always_comb begin
    w_gsum = {1'b0, r_gcnt};
    for (int c = 0; c < CHANNELS; c++) begin
      w_gsum = w_gsum + 17'(glitch_o[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gcnt <= '0;
    end else if (cnt_clr) begin
      r_gcnt <= '0;
    end else if (w_gsum[16]) begin
      r_gcnt <= 16'hFFFF;
    end else begin
      r_gcnt <= w_gsum[15:0];
    end
  end

  assign glitch_cnt = r_gcnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inertial_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_inertial_filter
// Purpose  : Self-checking bench for inertial_filter. Three instances share
//            the stimulus: DUT0 (DELAY_CYC=5, RST_VAL=0), DUT1 (DELAY_CYC=5,
//            RST_VAL=1) and DUT2 (DELAY_CYC=1). Each vector names the
//            instance whose outputs it checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inertial_filter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [3:0] din;
  logic [3:0] dout0, dout1, dout2;
  logic [3:0] gl0, gl1, gl2;
  logic       busy0, busy1, busy2;
`ifdef INERTIAL_FILTER_GLITCH_CNT_EN
  logic        cnt_clr;
  logic [15:0] gc0, gc1, gc2;
`endif

  always #5 clk = ~clk;

  inertial_filter #(.CHANNELS(4), .DELAY_CYC(5), .RST_VAL(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .din(din),
    .dout(dout0), .glitch_o(gl0), .busy(busy0)
`ifdef INERTIAL_FILTER_GLITCH_CNT_EN
    , .cnt_clr(cnt_clr), .glitch_cnt(gc0)
`endif
  );

  inertial_filter #(.CHANNELS(4), .DELAY_CYC(5), .RST_VAL(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .din(din),
    .dout(dout1), .glitch_o(gl1), .busy(busy1)
`ifdef INERTIAL_FILTER_GLITCH_CNT_EN
    , .cnt_clr(cnt_clr), .glitch_cnt(gc1)
`endif
  );

  inertial_filter #(.CHANNELS(4), .DELAY_CYC(1), .RST_VAL(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .din(din),
    .dout(dout2), .glitch_o(gl2), .busy(busy2)
`ifdef INERTIAL_FILTER_GLITCH_CNT_EN
    , .cnt_clr(cnt_clr), .glitch_cnt(gc2)
`endif
  );

  typedef struct {
    int          dsel;
    logic [3:0]  din;
    logic        en;
    logic        mode;
    logic        clr;
    logic [3:0]  e_dout;
    logic [3:0]  e_gl;
    logic        e_busy;
    logic        chk_gc;
    logic [15:0] e_gc;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add_n(input int n, input int s, input logic [3:0] d,
                       input logic e, input logic m, input logic c,
                       input logic [3:0] ed, input logic [3:0] eg,
                       input logic eb, input logic cg, input logic [15:0] egc);
    vec_t v;
    v.dsel = s; v.din = d; v.en = e; v.mode = m; v.clr = c;
    v.e_dout = ed; v.e_gl = eg; v.e_busy = eb; v.chk_gc = cg; v.e_gc = egc;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(input string nm, input int idx,
                       input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s (vec %0d): got %h, expected %h", nm, idx, act, req);
    end
  endtask

  // Drive one vector, let one edge pass, compare against the queued record
  task automatic apply(input int idx);
    vec_t v;
    vec_t x;
    logic [3:0]  ad, ag;
    logic        ab;
    v = vecs[idx];
    din  = v.din;
    en   = v.en;
    mode = v.mode;
`ifdef INERTIAL_FILTER_GLITCH_CNT_EN
    cnt_clr = v.clr;
`endif
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    case (x.dsel)
      0:       begin ad = dout0; ag = gl0; ab = busy0; end
      1:       begin ad = dout1; ag = gl1; ab = busy1; end
      default: begin ad = dout2; ag = gl2; ab = busy2; end
    endcase
    check("dout",     idx, {12'b0, ad}, {12'b0, x.e_dout});
    check("glitch_o", idx, {12'b0, ag}, {12'b0, x.e_gl});
    check("busy",     idx, {15'b0, ab}, {15'b0, x.e_busy});
`ifdef INERTIAL_FILTER_GLITCH_CNT_EN
    if (x.chk_gc) check("glitch_cnt", idx, gc0, x.e_gc);
`endif
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) apply(i);
  endtask

  // Called one time unit after an edge; returns one time unit after the next
  task automatic do_reset();
    en = 1'b0; mode = 1'b0; din = 4'b0000;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_end, b1_end, b2_end, c_end;

    // ---------------- Segment A: DUT0, DELAY_CYC=5 ----------------
    // Long high on ch0: rises on the 5th edge, falls 5 edges after din falls
    add_n(4, 0, 4'b0001, 1, 0, 0, 4'b0000, 4'b0000, 1, 0, 0);
    add_n(6, 0, 4'b0001, 1, 0, 0, 4'b0001, 4'b0000, 0, 0, 0);
    add_n(4, 0, 4'b0000, 1, 0, 0, 4'b0001, 4'b0000, 1, 0, 0);
    add_n(1, 0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    // 4-cycle pulse on ch1 is swallowed with a one-cycle glitch_o
    add_n(4, 0, 4'b0010, 1, 0, 0, 4'b0000, 4'b0000, 1, 0, 0);
    add_n(1, 0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0010, 0, 0, 0);
    add_n(1, 0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 1, 16'd1);
    // second rejection, then clear on the edge that would count it
    add_n(2, 0, 4'b0010, 1, 0, 0, 4'b0000, 4'b0000, 1, 1, 16'd1);
    add_n(1, 0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0010, 0, 1, 16'd1);
    add_n(1, 0, 4'b0000, 1, 0, 1, 4'b0000, 4'b0000, 0, 1, 16'd0);
    add_n(1, 0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 1, 16'd0);
    // exactly DELAY_CYC-cycle pulse passes as a 5-cycle output pulse
    add_n(4, 0, 4'b0010, 1, 0, 0, 4'b0000, 4'b0000, 1, 0, 0);
    add_n(1, 0, 4'b0010, 1, 0, 0, 4'b0010, 4'b0000, 0, 0, 0);
    add_n(4, 0, 4'b0000, 1, 0, 0, 4'b0010, 4'b0000, 1, 0, 0);
    add_n(1, 0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    // switch to transport; 1-cycle pulse on ch2 reappears 5 edges on
    add_n(1, 0, 4'b0000, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add_n(1, 0, 4'b0100, 1, 1, 0, 4'b0000, 4'b0000, 1, 0, 0);
    add_n(3, 0, 4'b0000, 1, 1, 0, 4'b0000, 4'b0000, 1, 0, 0);
    add_n(1, 0, 4'b0000, 1, 1, 0, 4'b0100, 4'b0000, 1, 0, 0);
    add_n(1, 0, 4'b0000, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 0);
    // back to inertial, ch3 pending with cnt=3, then switch to transport
    add_n(1, 0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add_n(3, 0, 4'b1000, 1, 0, 0, 4'b0000, 4'b0000, 1, 0, 0);
    add_n(1, 0, 4'b1000, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add_n(4, 0, 4'b1000, 1, 1, 0, 4'b0000, 4'b0000, 1, 0, 0);
    add_n(1, 0, 4'b1000, 1, 1, 0, 4'b1000, 4'b0000, 0, 0, 0);
    add_n(4, 0, 4'b0000, 1, 1, 0, 4'b1000, 4'b0000, 1, 0, 0);
    add_n(1, 0, 4'b0000, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 0);
    a_end = vecs.size();

    // ---------------- Segment B1: DUT1 (RST_VAL=1) before async reset ----
    add_n(1, 1, 4'b0000, 1, 0, 0, 4'b1111, 4'b0000, 1, 0, 0);
    add_n(1, 1, 4'b0011, 1, 0, 0, 4'b1111, 4'b0011, 1, 0, 0);
    b1_end = vecs.size();

    // ---------------- Segment B2: DUT1 freeze with en=0 ----------------
    add_n(2, 1, 4'b0000, 1, 0, 0, 4'b1111, 4'b0000, 1, 0, 0);
    add_n(1, 1, 4'b1111, 0, 0, 0, 4'b1111, 4'b0000, 1, 0, 0);
    add_n(1, 1, 4'b0000, 0, 0, 0, 4'b1111, 4'b0000, 1, 0, 0);
    add_n(1, 1, 4'b1010, 0, 0, 0, 4'b1111, 4'b0000, 1, 0, 0);
    add_n(2, 1, 4'b0000, 1, 0, 0, 4'b1111, 4'b0000, 1, 0, 0);
    add_n(1, 1, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add_n(2, 1, 4'b1111, 1, 0, 0, 4'b0000, 4'b0000, 1, 0, 0);
    add_n(1, 1, 4'b0000, 1, 0, 0, 4'b0000, 4'b1111, 0, 0, 0);
    b2_end = vecs.size();

    // ---------------- Segment C: DUT2, DELAY_CYC=1, both modes ----------
    add_n(1, 2, 4'b0101, 1, 0, 0, 4'b0101, 4'b0000, 0, 0, 0);
    add_n(1, 2, 4'b1010, 1, 0, 0, 4'b1010, 4'b0000, 0, 0, 0);
    add_n(1, 2, 4'b0101, 1, 0, 0, 4'b0101, 4'b0000, 0, 0, 0);
    add_n(1, 2, 4'b1010, 1, 0, 0, 4'b1010, 4'b0000, 0, 0, 0);
    add_n(1, 2, 4'b1010, 1, 1, 0, 4'b1010, 4'b0000, 0, 0, 0);
    add_n(1, 2, 4'b0101, 1, 1, 0, 4'b0101, 4'b0000, 0, 0, 0);
    add_n(1, 2, 4'b1010, 1, 1, 0, 4'b1010, 4'b0000, 0, 0, 0);
    add_n(1, 2, 4'b0011, 1, 1, 0, 4'b0011, 4'b0000, 0, 0, 0);
    add_n(1, 2, 4'b1100, 1, 1, 0, 4'b1100, 4'b0000, 0, 0, 0);
    add_n(1, 2, 4'b0000, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 0);
    c_end = vecs.size();

    // ---------------- Power-on reset ----------------
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; din = 4'b0000;
`ifdef INERTIAL_FILTER_GLITCH_CNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("rst_dout0", -1, {12'b0, dout0}, 16'h0000);
    check("rst_gl0",   -1, {12'b0, gl0},   16'h0000);
    check("rst_busy0", -1, {15'b0, busy0}, 16'h0000);
    check("rst_dout1", -1, {12'b0, dout1}, 16'h000F);
    check("rst_busy1", -1, {15'b0, busy1}, 16'h0000);
    check("rst_dout2", -1, {12'b0, dout2}, 16'h0000);
`ifdef INERTIAL_FILTER_GLITCH_CNT_EN
    check("rst_gcnt0", -1, gc0, 16'h0000);
`endif
    @(posedge clk);
    #1;

    run_range(0, a_end);

    // Async reset mid-pending on the RST_VAL=1 instance, off the clock edge
    do_reset();
    run_range(a_end, b1_end);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dout1", -2, {12'b0, dout1}, 16'h000F);
    check("async_rst_gl1",   -2, {12'b0, gl1},   16'h0000);
    check("async_rst_busy1", -2, {15'b0, busy1}, 16'h0000);
    check("async_rst_dout0", -2, {12'b0, dout0}, 16'h0000);
    en = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_range(b1_end, b2_end);

    // glitch_o must drop as soon as en falls, without waiting for an edge
    en = 1'b0;
    #1;
    check("en_gate_gl1", -3, {12'b0, gl1}, 16'h0000);

    run_range(b2_end, c_end);

    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
